// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO accumulate unit: op encodings, FSM states,
// default register width.
package hilo_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_MADD = 3'd2;
    localparam logic [2:0] OP_MSUB = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } hilo_state_t;

endpackage

// File: rtl/hilo_addsub64.sv
// Combinational {HI,LO} +/- product. Wraps modulo 2^W; the same adder serves
// signed and unsigned forms because sign extension happened upstream.
module hilo_addsub64 #(
    parameter int W = 64
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] p,
    input  logic         sub,
    output logic [W-1:0] res
);

    // Single adder; subtraction selected by the latched direction bit.
    always_comb begin
        res = sub ? (acc - p) : (acc + p);
    end

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO special-register stage behind the 32x32 multiplier.
// MULT capture, MTHI/MTLO writes, two-cycle MADD/MSUB, MFHI/MFLO read port.
// Optional macro HILO_FWD_EN: bypass written / accumulated values onto rd_data
// and never stall.
module hilo_acc_unit
    import hilo_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [2:0]          op_code,
    input  logic [2*DATA_W-1:0] product,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_sel,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic                stall,
    output logic                busy
);

    localparam int PW = 2 * DATA_W;

    hilo_state_t         state, state_nxt;
    logic [DATA_W-1:0]   hi, lo;
    logic [PW-1:0]       p_q;      // stage-1 latched product
    logic                sub_q;    // stage-1 latched direction
    logic [PW-1:0]       sum;
    logic                accept;
    logic                is_acc_op;

    assign op_ready  = (state == IDLE);
    assign busy      = (state == ACC);
    assign accept    = op_valid & op_ready;
    assign is_acc_op = (op_code == OP_MADD) || (op_code == OP_MSUB);

    hilo_addsub64 #(.W(PW)) u_addsub (
        .acc (({hi, lo})),
        .p   (p_q),
        .sub (sub_q),
        .res (sum)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: ACC lasts exactly one cycle after an accepted MADD/MSUB.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_acc_op) state_nxt = ACC;
            ACC:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // HI/LO and stage-1 registers; a reset during ACC drops the pending sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= RESET_VAL;
            lo    <= RESET_VAL;
            p_q   <= '0;
            sub_q <= 1'b0;
        end else if (state == ACC) begin
            {hi, lo} <= sum;
        end else if (accept) begin
            case (op_code)
                OP_MUL:  {hi, lo} <= product;
                OP_MTHI: hi <= wr_data;
                OP_MTLO: lo <= wr_data;
                OP_MADD: begin p_q <= product; sub_q <= 1'b0; end
                OP_MSUB: begin p_q <= product; sub_q <= 1'b1; end
                default: ;
            endcase
        end
    end

`ifdef HILO_FWD_EN
    // Read port with bypass of the value committing at the next edge.
    always_comb begin
        rd_data = rd_sel ? hi : lo;
        if (busy) begin
            rd_data = rd_sel ? sum[PW-1:DATA_W] : sum[DATA_W-1:0];
        end else if (accept && rd_en) begin
            case (op_code)
                OP_MUL:  rd_data = rd_sel ? product[PW-1:DATA_W] : product[DATA_W-1:0];
                OP_MTHI: if (rd_sel)  rd_data = wr_data;
                OP_MTLO: if (!rd_sel) rd_data = wr_data;
                default: ;
            endcase
        end
    end

    assign stall = 1'b0;
`else
    // Read port straight from the registers; writes show after the edge.
    always_comb begin
        rd_data = rd_sel ? hi : lo;
    end

    assign stall = rd_en & busy;
`endif

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed bench for hilo_acc_unit. Expected HI/LO contents are queued when an
// op is driven and popped/compared once the result should be architecturally
// visible. Handshake/stall checks are made in place.
module tb_hilo_acc_unit;
    import hilo_pkg::*;

    logic        clk, rst_n;
    logic        op_valid, op_ready;
    logic [2:0]  op_code;
    logic [63:0] product;
    logic [31:0] wr_data;
    logic        rd_sel, rd_en;
    logic [31:0] rd_data;
    logic        stall, busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    hilo_acc_unit #(.DATA_W(32), .RESET_VAL(32'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .product  (product),
        .wr_data  (wr_data),
        .rd_sel   (rd_sel),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .stall    (stall),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_hilo(input string tag, input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.tag = {tag, "_hi"}; e.sel = 1'b1; e.val = h; sb.push_back(e);
        e.tag = {tag, "_lo"}; e.sel = 1'b0; e.val = l; sb.push_back(e);
    endtask

    // Compare every queued expectation against the read port.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_sel = e.sel;
            #1;
            chk(e.tag, {32'h0, rd_data}, {32'h0, e.val});
        end
    endtask

    // One accepted op in IDLE; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [63:0] p, input logic [31:0] wd);
        op_valid = 1'b1; op_code = op; product = p; wr_data = wd;
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = OP_NONE;
    endtask

    initial begin
        // Reset asserted while a MUL is presented.
        rst_n = 1'b0; op_valid = 1'b1; op_code = OP_MUL;
        product = 64'h1234_5678_9ABC_DEF0; wr_data = '0; rd_sel = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  {63'h0, busy},     64'h0);
        chk("rst_ready", {63'h0, op_ready}, 64'h1);
        rd_en = 1'b1; #1;
        chk("rst_stall", {63'h0, stall},    64'h0);
        rd_en = 1'b0;
        push_hilo("rst", 32'h0, 32'h0);
        drain();
        rst_n = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = OP_NONE;
        push_hilo("mul0", 32'h1234_5678, 32'h9ABC_DEF0);
        drain();

        // MUL then MADD with carry into HI.
        issue(OP_MUL, 64'h0000_0001_FFFF_FFFF, '0);
        issue(OP_MADD, 64'h1, '0);
        chk("madd_busy",  {63'h0, busy},     64'h1);
        chk("madd_ready", {63'h0, op_ready}, 64'h0);
        rd_en = 1'b1; rd_sel = 1'b1; #1;
`ifdef HILO_FWD_EN
        chk("madd_stall", {63'h0, stall}, 64'h0);
        chk("madd_fwd",   {32'h0, rd_data}, 64'h2);
`else
        chk("madd_stall", {63'h0, stall}, 64'h1);
        chk("madd_old",   {32'h0, rd_data}, 64'h1);
`endif
        @(posedge clk); #1;
        chk("madd_stall_off", {63'h0, stall}, 64'h0);
        chk("madd_idle",      {63'h0, busy},  64'h0);
        rd_en = 1'b0;
        push_hilo("madd", 32'h2, 32'h0);
        drain();

        // MTHI / MTLO.
        issue(OP_MTHI, '0, 32'hDEAD_BEEF);
        issue(OP_MTLO, '0, 32'h0BAD_F00D);
        push_hilo("mt", 32'hDEAD_BEEF, 32'h0BAD_F00D);
        drain();

        // MSUB underflow, second MSUB held during ACC.
        issue(OP_MUL, 64'h0, '0);
        op_valid = 1'b1; op_code = OP_MSUB; product = 64'h1;
        @(posedge clk); #1;
        chk("msub_ready_acc", {63'h0, op_ready}, 64'h0);
        @(posedge clk); #1;
        chk("msub2_not_acc", {63'h0, busy}, 64'h0);
        push_hilo("msub1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = OP_NONE;
        chk("msub2_acc", {63'h0, busy}, 64'h1);
        @(posedge clk); #1;
        push_hilo("msub2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        drain();

        // MADD wrap-around.
        issue(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, '0);
        issue(OP_MADD, 64'h1, '0);
        @(posedge clk); #1;
        push_hilo("wrap", 32'h0, 32'h0);
        drain();

        // Async reset mid-ACC drops the pending accumulate.
        issue(OP_MUL, 64'h0000_0007_0000_0009, '0);
        issue(OP_MADD, 64'h5, '0);
        rst_n = 1'b0; #1;
        chk("rst_acc_busy",  {63'h0, busy},     64'h0);
        chk("rst_acc_ready", {63'h0, op_ready}, 64'h1);
        push_hilo("rst_acc", 32'h0, 32'h0);
        drain();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_hilo("rst_late", 32'h0, 32'h0);
        drain();

        // OP_NONE and undefined code with op_valid: no change.
        issue(OP_MUL, 64'hAAAA_0000_0000_BBBB, '0);
        issue(OP_NONE, 64'h1111_1111_1111_1111, 32'h2222_2222);
        issue(3'd7,    64'h3333_3333_3333_3333, 32'h4444_4444);
        chk("undef_busy", {63'h0, busy}, 64'h0);
        push_hilo("undef", 32'hAAAA_0000, 32'h0000_BBBB);
        drain();

        // Read and write LO in the same IDLE cycle.
        op_valid = 1'b1; op_code = OP_MTLO; wr_data = 32'h55; rd_en = 1'b1; rd_sel = 1'b0;
        #1;
`ifdef HILO_FWD_EN
        chk("rw_same", {32'h0, rd_data}, 64'h55);
`else
        chk("rw_same", {32'h0, rd_data}, 64'h0000_BBBB);
`endif
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = OP_NONE; rd_en = 1'b0;
        push_hilo("rw_after", 32'hAAAA_0000, 32'h55);
        drain();

        // LO read during ACC.
        issue(OP_MUL, 64'h4, '0);
        issue(OP_MADD, 64'h3, '0);
        rd_en = 1'b1; rd_sel = 1'b0; #1;
`ifdef HILO_FWD_EN
        chk("acc_rd",    {32'h0, rd_data}, 64'h7);
        chk("acc_stall", {63'h0, stall},   64'h0);
`else
        chk("acc_rd",    {32'h0, rd_data}, 64'h4);
        chk("acc_stall", {63'h0, stall},   64'h1);
`endif
        @(posedge clk); #1;
        rd_en = 1'b0;
        push_hilo("acc_done", 32'h0, 32'h7);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
